// File: rtl/exc_pkg.sv
// Shared types and constants for the trap controller: FSM states, event kinds,
// synchronous exception cause table and interrupt/vector constants.
package exc_pkg;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_FLUSH    = 2'd1,
    ST_REDIRECT = 2'd2
  } state_t;

  typedef enum logic [1:0] {
    EV_NONE = 2'd0,
    EV_EXC  = 2'd1,
    EV_IRQ  = 2'd2,
    EV_MRET = 2'd3
  } ev_kind_t;

  localparam logic [31:0] IRQ_CAUSE_EXT  = 32'h8000_000B;
  localparam logic [1:0]  MTVEC_MODE_VEC = 2'b01;
  localparam logic [31:0] IRQ_VEC_OFFSET = 32'h0000_002C;

  // Cause code per source index; unlisted indexes report illegal instruction.
  function automatic logic [3:0] exc_code(input int unsigned idx);
    case (idx)
      0:       exc_code = 4'd2;
      1:       exc_code = 4'd0;
      2:       exc_code = 4'd4;
      3:       exc_code = 4'd6;
      default: exc_code = 4'd2;
    endcase
  endfunction

endpackage

// File: rtl/exc_prio_enc.sv
// Lowest-index-first priority encoder: valid when any request is set,
// idx points at the lowest set bit.
module exc_prio_enc #(
  parameter int N  = 4,
  parameter int IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req,
  output logic          valid,
  output logic [IW-1:0] idx
);

  always_comb begin
    valid = |req;
    idx   = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (req[i]) idx = IW'(i);
    end
  end

endmodule

// File: rtl/exception_ctrl.sv
// Trap controller: arbitrates EX exceptions, external interrupt and mret,
// captures trap CSRs, holds a flush, then issues a single-cycle PC redirect.
module exception_ctrl
  import exc_pkg::*;
#(
  parameter int NUM_SRC     = 4,
  parameter int FLUSH_CYC   = 2,
  parameter bit VECTORED_EN = 1'b1
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [NUM_SRC-1:0] exc_req_ex,
  input  logic [31:0]        pc_ex,
  input  logic [31:0]        tval_ex,
  input  logic               mret_ex,
  input  logic               ext_irq,
  input  logic               csr_mstatus_mie,
  input  logic               csr_mie_meie,
  input  logic [31:0]        csr_mtvec,
  input  logic [31:0]        csr_mepc,
  output logic               g_exception,
  output logic               trap_we,
  output logic               mret_we,
  output logic [31:0]        mcause_o,
  output logic [31:0]        mepc_o,
  output logic [31:0]        mtval_o,
  output logic               jump_req,
  output logic [31:0]        jump_pc,
  output logic               busy
);

  localparam int IW = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1;
  localparam int CW = (FLUSH_CYC > 1) ? $clog2(FLUSH_CYC) : 1;
  localparam logic [CW-1:0] CNT_LOAD = CW'(FLUSH_CYC - 1);

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q;
  ev_kind_t      kind_q, ev_kind;
  logic [31:0]   target_q, ev_target;
  logic          exc_valid;
  logic [IW-1:0] exc_idx;
  logic          irq_take;
  logic          accept;
  logic [31:0]   mtvec_base;
  logic [31:0]   exc_cause;

  exc_prio_enc #(.N(NUM_SRC), .IW(IW)) u_prio (
    .req   (exc_req_ex),
    .valid (exc_valid),
    .idx   (exc_idx)
  );

  assign irq_take   = ext_irq & csr_mstatus_mie & csr_mie_meie;
  assign mtvec_base = {csr_mtvec[31:2], 2'b00};
  assign exc_cause  = {28'b0, exc_code(32'(exc_idx))};

  // Event arbitration only matters in IDLE; other states ignore all inputs.
  always_comb begin
    ev_kind   = EV_NONE;
    ev_target = '0;
    if (exc_valid) begin
      ev_kind   = EV_EXC;
      ev_target = mtvec_base;
    end else if (irq_take) begin
      ev_kind   = EV_IRQ;
      ev_target = (VECTORED_EN && csr_mtvec[1:0] == MTVEC_MODE_VEC)
                  ? mtvec_base + IRQ_VEC_OFFSET : mtvec_base;
    end else if (mret_ex) begin
      ev_kind   = EV_MRET;
      ev_target = csr_mepc;
    end
  end

  assign accept = (state_q == ST_IDLE) && (ev_kind != EV_NONE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:     if (accept) state_d = ST_FLUSH;
      ST_FLUSH:    if (cnt_q == '0) state_d = ST_REDIRECT;
      ST_REDIRECT: state_d = ST_IDLE;
      default:     state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q    <= '0;
      kind_q   <= EV_NONE;
      target_q <= '0;
      mcause_o <= '0;
      mepc_o   <= '0;
      mtval_o  <= '0;
    end else begin
      if (accept) begin
        cnt_q    <= CNT_LOAD;
        kind_q   <= ev_kind;
        target_q <= ev_target;
        if (ev_kind == EV_EXC) begin
          mcause_o <= exc_cause;
          mepc_o   <= pc_ex;
          mtval_o  <= tval_ex;
        end else if (ev_kind == EV_IRQ) begin
          mcause_o <= IRQ_CAUSE_EXT;
          mepc_o   <= pc_ex;
          mtval_o  <= '0;
        end
      end else if (state_q == ST_FLUSH && cnt_q != '0) begin
        cnt_q <= cnt_q - 1'b1;
      end
    end
  end

  // The counter only counts down, so the load value marks the first FLUSH cycle.
  always_comb begin
    g_exception = (rst_n && accept) || (state_q == ST_FLUSH);
    trap_we     = (state_q == ST_FLUSH) && (cnt_q == CNT_LOAD) && (kind_q != EV_MRET);
    mret_we     = (state_q == ST_FLUSH) && (cnt_q == CNT_LOAD) && (kind_q == EV_MRET);
    jump_req    = (state_q == ST_REDIRECT);
    jump_pc     = jump_req ? target_q : '0;
    busy        = (state_q != ST_IDLE);
  end

endmodule

// File: tb/tb_exception_ctrl.sv
// Bench for exception_ctrl: directed vector table, hand sequences for reset and
// mid-flush behaviour, and randomized events against a rule-level model.
module tb_exception_ctrl;

  localparam int FLUSH_CYC = 2;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [3:0]  exc_req_ex;
  logic [31:0] pc_ex, tval_ex, csr_mtvec, csr_mepc;
  logic        mret_ex, ext_irq, csr_mstatus_mie, csr_mie_meie;

  logic        g_exception, trap_we, mret_we, jump_req, busy;
  logic [31:0] mcause_o, mepc_o, mtval_o, jump_pc;
  logic        nv_g_exception, nv_trap_we, nv_mret_we, nv_jump_req, nv_busy;
  logic [31:0] nv_mcause_o, nv_mepc_o, nv_mtval_o, nv_jump_pc;

  int n_tests = 0;
  int n_fail  = 0;

  logic [31:0] m_cause = '0, m_epc = '0, m_tval = '0;

  typedef struct {
    logic [3:0]  exc_req;
    logic        irq, mie, meie, mret;
    logic [31:0] pc, tval, mtvec, mepc;
    int          kind;        // 0 none, 1 trap, 2 mret
    logic [31:0] cause, epc, tval_o, jpc, jpc_nv;
  } vec_t;

  exception_ctrl #(.NUM_SRC(4), .FLUSH_CYC(FLUSH_CYC), .VECTORED_EN(1'b1)) dut (
    .clk(clk), .rst_n(rst_n), .exc_req_ex(exc_req_ex), .pc_ex(pc_ex), .tval_ex(tval_ex),
    .mret_ex(mret_ex), .ext_irq(ext_irq), .csr_mstatus_mie(csr_mstatus_mie),
    .csr_mie_meie(csr_mie_meie), .csr_mtvec(csr_mtvec), .csr_mepc(csr_mepc),
    .g_exception(g_exception), .trap_we(trap_we), .mret_we(mret_we), .mcause_o(mcause_o),
    .mepc_o(mepc_o), .mtval_o(mtval_o), .jump_req(jump_req), .jump_pc(jump_pc), .busy(busy)
  );

  exception_ctrl #(.NUM_SRC(4), .FLUSH_CYC(FLUSH_CYC), .VECTORED_EN(1'b0)) dut_nv (
    .clk(clk), .rst_n(rst_n), .exc_req_ex(exc_req_ex), .pc_ex(pc_ex), .tval_ex(tval_ex),
    .mret_ex(mret_ex), .ext_irq(ext_irq), .csr_mstatus_mie(csr_mstatus_mie),
    .csr_mie_meie(csr_mie_meie), .csr_mtvec(csr_mtvec), .csr_mepc(csr_mepc),
    .g_exception(nv_g_exception), .trap_we(nv_trap_we), .mret_we(nv_mret_we),
    .mcause_o(nv_mcause_o), .mepc_o(nv_mepc_o), .mtval_o(nv_mtval_o),
    .jump_req(nv_jump_req), .jump_pc(nv_jump_pc), .busy(nv_busy)
  );

  // clock / watchdog
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic clear_inputs();
    exc_req_ex = '0; mret_ex = 1'b0; ext_irq = 1'b0;
    pc_ex = '0; tval_ex = '0;
  endtask

  task automatic noise_inputs();
    exc_req_ex = 4'($urandom_range(1, 15));
    mret_ex    = 1'($urandom_range(0, 1));
    ext_irq    = 1'b1;
    pc_ex      = $urandom; tval_ex = $urandom;
  endtask

  task automatic drive(input vec_t v);
    exc_req_ex = v.exc_req; ext_irq = v.irq; csr_mstatus_mie = v.mie;
    csr_mie_meie = v.meie; mret_ex = v.mret; pc_ex = v.pc; tval_ex = v.tval;
    csr_mtvec = v.mtvec; csr_mepc = v.mepc;
  endtask

  // Rule-level reference: who wins, what gets recorded, where the PC goes.
  function automatic vec_t predict(input vec_t v);
    int    codes[4] = '{2, 0, 4, 6};
    vec_t  r = v;
    logic [31:0] base = v.mtvec & 32'hFFFF_FFFC;
    r.kind = 0; r.cause = m_cause; r.epc = m_epc; r.tval_o = m_tval;
    r.jpc = '0; r.jpc_nv = '0;
    if (v.exc_req != 0) begin
      int w = -1;
      for (int i = 3; i >= 0; i--) if (v.exc_req[i]) w = i;
      r.kind = 1; r.cause = codes[w]; r.epc = v.pc; r.tval_o = v.tval;
      r.jpc = base; r.jpc_nv = base;
    end else if (v.irq && v.mie && v.meie) begin
      r.kind = 1; r.cause = 32'h8000_000B; r.epc = v.pc; r.tval_o = 0;
      r.jpc = (v.mtvec % 4 == 1) ? base + 4 * 11 : base;
      r.jpc_nv = base;
    end else if (v.mret) begin
      r.kind = 2; r.jpc = v.mepc; r.jpc_nv = v.mepc;
    end
    return r;
  endfunction

  // One full event: acceptance, FLUSH cycles, REDIRECT; checks along the way.
  task automatic apply(input vec_t v, input bit noise);
    @(negedge clk);
    drive(v);
    #1;
    chk("idle_busy", busy, 0);
    chk("idle_jump_req", jump_req, 0);
    chk("accept_g_exc", g_exception, (v.kind != 0));
    if (v.kind == 1) begin m_cause = v.cause; m_epc = v.epc; m_tval = v.tval_o; end
    if (v.kind == 0) return;
    for (int i = 0; i < FLUSH_CYC; i++) begin
      @(negedge clk);
      if (noise) noise_inputs(); else clear_inputs();
      #1;
      chk("flush_g_exc", g_exception, 1);
      chk("flush_busy", busy, 1);
      chk("flush_jump_req", jump_req, 0);
      chk("flush_jump_pc", jump_pc, 0);
      chk("flush_trap_we", trap_we, (i == 0 && v.kind == 1));
      chk("flush_mret_we", mret_we, (i == 0 && v.kind == 2));
      chk("mcause", mcause_o, v.cause);
      chk("mepc", mepc_o, v.epc);
      chk("mtval", mtval_o, v.tval_o);
    end
    @(negedge clk);
    clear_inputs();
    #1;
    chk("redir_jump_req", jump_req, 1);
    chk("redir_jump_pc", jump_pc, v.jpc);
    chk("redir_jump_pc_nv", nv_jump_pc, v.jpc_nv);
    chk("redir_g_exc", g_exception, 0);
    chk("redir_busy", busy, 1);
    chk("redir_trap_we", trap_we, 0);
  endtask

  function automatic vec_t mk(input logic [3:0] er, input logic irq, input logic mie,
                              input logic meie, input logic mret, input logic [31:0] pc,
                              input logic [31:0] tval, input logic [31:0] mtvec,
                              input logic [31:0] mepc, input int kind,
                              input logic [31:0] cause, input logic [31:0] epc,
                              input logic [31:0] tval_o, input logic [31:0] jpc,
                              input logic [31:0] jpc_nv);
    vec_t v;
    v.exc_req = er; v.irq = irq; v.mie = mie; v.meie = meie; v.mret = mret;
    v.pc = pc; v.tval = tval; v.mtvec = mtvec; v.mepc = mepc; v.kind = kind;
    v.cause = cause; v.epc = epc; v.tval_o = tval_o; v.jpc = jpc; v.jpc_nv = jpc_nv;
    return v;
  endfunction

  vec_t tbl[8];

  initial begin
    // hand-computed directed vectors, applied in order (mret rows expect the
    // trap values left by the preceding row)
    tbl[0] = mk(4'b1111, 0, 0, 0, 0, 32'h040, 32'h0BAD, 32'h200, 0, 1, 2, 32'h040, 32'h0BAD, 32'h200, 32'h200);
    tbl[1] = mk(4'b0001, 0, 0, 0, 0, 32'h100, 32'hFFFF_FFFF, 32'h200, 0, 1, 2, 32'h100, 32'hFFFF_FFFF, 32'h200, 32'h200);
    tbl[2] = mk(4'b1100, 1, 1, 1, 1, 32'h108, 32'h1234, 32'h201, 32'h999, 1, 4, 32'h108, 32'h1234, 32'h200, 32'h200);
    tbl[3] = mk(4'b0000, 1, 1, 1, 0, 32'h10C, 32'h5555, 32'h201, 0, 1, 32'h8000_000B, 32'h10C, 0, 32'h22C, 32'h200);
    tbl[4] = mk(4'b0000, 0, 1, 1, 1, 32'h110, 32'h7777, 32'h201, 32'h104, 2, 32'h8000_000B, 32'h10C, 0, 32'h104, 32'h104);
    tbl[5] = mk(4'b1010, 0, 0, 0, 0, 32'h300, 32'h303, 32'h1003, 0, 1, 0, 32'h300, 32'h303, 32'h1000, 32'h1000);
    tbl[6] = mk(4'b1000, 1, 1, 1, 0, 32'h400, 32'h402, 32'h202, 0, 1, 6, 32'h400, 32'h402, 32'h200, 32'h200);
    tbl[7] = mk(4'b0000, 1, 0, 1, 1, 32'h500, 32'h0, 32'h201, 32'h888, 2, 6, 32'h400, 32'h402, 32'h888, 32'h888);

    // reset: outputs held at 0 even with every request asserted
    rst_n = 1'b0;
    clear_inputs();
    exc_req_ex = 4'b1111; csr_mstatus_mie = 1; csr_mie_meie = 1; csr_mtvec = 32'h200; csr_mepc = 0;
    repeat (2) @(negedge clk);
    #1;
    chk("rst_g_exc", g_exception, 0);
    chk("rst_trap_we", trap_we, 0);
    chk("rst_mret_we", mret_we, 0);
    chk("rst_mcause", mcause_o, 0);
    chk("rst_mepc", mepc_o, 0);
    chk("rst_mtval", mtval_o, 0);
    chk("rst_jump_req", jump_req, 0);
    chk("rst_jump_pc", jump_pc, 0);
    chk("rst_busy", busy, 0);
    exc_req_ex = '0;
    rst_n = 1'b1;

    // directed table; row 1 drives noise during FLUSH, which must be ignored
    for (int i = 0; i < 8; i++) apply(tbl[i], (i == 1));

    // reset dropped mid-FLUSH: immediate IDLE, cleared outputs, no redirect
    @(negedge clk);
    exc_req_ex = 4'b0100; pc_ex = 32'h600; tval_ex = 32'h601;
    @(negedge clk);
    clear_inputs();
    #1;
    chk("mid_busy", busy, 1);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_g_exc", g_exception, 0);
    chk("mid_rst_mcause", mcause_o, 0);
    m_cause = '0; m_epc = '0; m_tval = '0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      #1;
      chk("post_rst_jump_req", jump_req, 0);
      chk("post_rst_busy", busy, 0);
    end

    // randomized events against the reference model
    for (int i = 0; i < 60; i++) begin
      vec_t v;
      v.exc_req = ($urandom_range(0, 2) == 0) ? 4'($urandom_range(1, 15)) : 4'b0;
      v.irq  = 1'($urandom_range(0, 1));
      v.mie  = 1'($urandom_range(0, 1));
      v.meie = 1'($urandom_range(0, 1));
      v.mret = 1'($urandom_range(0, 1));
      v.pc = $urandom & 32'hFFFF_FFFC; v.tval = $urandom;
      v.mtvec = $urandom; v.mepc = $urandom;
      v = predict(v);
      apply(v, 1'($urandom_range(0, 1)));
    end

    @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
